layer_sequencer: RTL and testbench

Sequencer for one fully connected layer of the digit-recognition network, built on a single shared multiply-accumulate unit instead of one MAC per neuron. It walks every neuron of the layer and every input element, and issues read addresses to the input buffer, weight memory and bias memory. For each neuron it forms `sum(x*w)`, applies a fixed-point shift, adds the bias, saturates the result, and writes one output word. It sits between the synchronous-read activation/weight memories and the next layer's input buffer.

---
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_layer_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - shared-MAC sequencer for one fully connected layer
// Optional LAYER_SEQ_RELU_EN: clamp negative saturated results to zero.
module layer_sequencer #(
  parameter int NUMBER_NEURON   = 30,
  parameter int INPUT_DATA_SIZE = 196,
  parameter int RESOLUTION      = 8,
  parameter int FRAC_BITS       = 0,
  localparam int IN_AW = (INPUT_DATA_SIZE > 1) ? $clog2(INPUT_DATA_SIZE) : 1,
  localparam int W_AW  = (NUMBER_NEURON * INPUT_DATA_SIZE > 1) ?
                         $clog2(NUMBER_NEURON * INPUT_DATA_SIZE) : 1,
  localparam int N_AW  = (NUMBER_NEURON > 1) ? $clog2(NUMBER_NEURON) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [IN_AW-1:0]             in_addr,
  input  logic signed [RESOLUTION-1:0] in_data,
  output logic [W_AW-1:0]              w_addr,
  input  logic signed [RESOLUTION-1:0] w_data,
  output logic [N_AW-1:0]              b_addr,
  input  logic signed [RESOLUTION-1:0] b_data,
  output logic                         out_we,
  output logic [N_AW-1:0]              out_addr,
  output logic signed [RESOLUTION-1:0] out_data
);

  localparam int ACC_W     = 2 * RESOLUTION + $clog2(INPUT_DATA_SIZE) + 1;
  localparam int SAT_MAX_I = 2 ** (RESOLUTION - 1) - 1;
  localparam int SAT_MIN_I = -(2 ** (RESOLUTION - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(SAT_MAX_I);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(SAT_MIN_I);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE} state_t;

  state_t                        state_q, state_d;
  logic [N_AW-1:0]               n_q, n_d;
  logic [IN_AW-1:0]              k_q, k_d;
  logic [W_AW-1:0]               w_q, w_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          we_q, we_d;
  logic [N_AW-1:0]               out_addr_q, out_addr_d;
  logic signed [RESOLUTION-1:0]  out_data_q, out_data_d;

  logic signed [2*RESOLUTION-1:0] prod;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [ACC_W-1:0]        acc_shift;
  logic signed [ACC_W:0]          res_wide;
  logic signed [RESOLUTION-1:0]   res_sat;
  logic signed [RESOLUTION-1:0]   res_final;

  // Memory data lags the address by one cycle, so the product here belongs to k-1.
  assign prod      = in_data * w_data;
  assign acc_sum   = acc_q + {{(ACC_W - 2*RESOLUTION){prod[2*RESOLUTION-1]}}, prod};
  assign acc_shift = acc_sum >>> FRAC_BITS;
  assign res_wide  = {acc_shift[ACC_W-1], acc_shift}
                   + {{(ACC_W + 1 - RESOLUTION){b_data[RESOLUTION-1]}}, b_data};

  always_comb begin
    res_sat = res_wide[RESOLUTION-1:0];
    if (res_wide > SAT_MAX) begin
      res_sat = {1'b0, {(RESOLUTION-1){1'b1}}};
    end else if (res_wide < SAT_MIN) begin
      res_sat = {1'b1, {(RESOLUTION-1){1'b0}}};
    end
  end

`ifdef LAYER_SEQ_RELU_EN
  assign res_final = res_sat[RESOLUTION-1] ? '0 : res_sat;
`else
  assign res_final = res_sat;
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    w_d        = w_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          n_d     = '0;
          k_d     = '0;
          w_d     = '0;
          busy_d  = 1'b1;
        end
      end
      S_MAC: begin
        acc_d = (k_q == '0) ? '0 : acc_sum;
        if (k_q == IN_AW'(INPUT_DATA_SIZE - 1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IN_AW'(1);
          w_d = w_q + W_AW'(1);
        end
      end
      S_DRAIN: begin
        // Last product lands here; the result is registered straight into WRITE.
        acc_d      = acc_sum;
        state_d    = S_WRITE;
        we_d       = 1'b1;
        out_addr_d = n_q;
        out_data_d = res_final;
      end
      S_WRITE: begin
        if (n_q != N_AW'(NUMBER_NEURON - 1)) begin
          n_d     = n_q + N_AW'(1);
          k_d     = '0;
          w_d     = w_q + W_AW'(1);
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      w_q        <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      w_q        <= w_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_we   = we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign in_addr  = k_q;
  assign w_addr   = w_q;
  assign b_addr   = n_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized and directed bench for layer_sequencer
// Two instances share memories: FRAC_BITS=0 and FRAC_BITS=4.
module tb_layer_sequencer;
  localparam int NN = 2;
  localparam int KK = 4;
  localparam int PERIOD = KK + 2;
  localparam int RUN_LEN = NN * PERIOD + 1;

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic signed [7:0] in_mem [KK];
  logic signed [7:0] w_mem  [NN*KK];
  logic signed [7:0] b_mem  [NN];

  logic              busy0, done0, we0, busy4, done4, we4;
  logic [1:0]        ia0, ia4;
  logic [2:0]        wa0, wa4;
  logic [0:0]        ba0, ba4, oa0, oa4;
  logic signed [7:0] od0, od4;
  logic signed [7:0] id0, wd0, bd0, id4, wd4, bd4;

  int errors = 0;
  int checks = 0;
  int last_addr, last0, last4;

  always #5 clk = ~clk;

  layer_sequencer #(.NUMBER_NEURON(NN), .INPUT_DATA_SIZE(KK), .RESOLUTION(8), .FRAC_BITS(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .in_addr(ia0), .in_data(id0), .w_addr(wa0), .w_data(wd0), .b_addr(ba0), .b_data(bd0),
    .out_we(we0), .out_addr(oa0), .out_data(od0));

  layer_sequencer #(.NUMBER_NEURON(NN), .INPUT_DATA_SIZE(KK), .RESOLUTION(8), .FRAC_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .busy(busy4), .done(done4),
    .in_addr(ia4), .in_data(id4), .w_addr(wa4), .w_data(wd4), .b_addr(ba4), .b_data(bd4),
    .out_we(we4), .out_addr(oa4), .out_data(od4));

  always @(posedge clk) begin
    id0 <= in_mem[ia0];
    wd0 <= w_mem[wa0];
    bd0 <= b_mem[ba0];
    id4 <= in_mem[ia4];
    wd4 <= w_mem[wa4];
    bd4 <= b_mem[ba4];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int n, input int frac);
    int acc = 0;
    int r;
    for (int k = 0; k < KK; k++) begin
      int a = in_mem[k];
      int b = w_mem[n*KK + k];
      acc += a * b;
    end
    r = (acc >>> frac) + int'(b_mem[n]);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`ifdef LAYER_SEQ_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic set_mem(input int xv, input int w0, input int b0, input int w1, input int b1);
    for (int k = 0; k < KK; k++) begin
      in_mem[k]     = 8'(xv);
      w_mem[k]      = 8'(w0);
      w_mem[KK + k] = 8'(w1);
    end
    b_mem[0] = 8'(b0);
    b_mem[1] = 8'(b1);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < KK; i++) in_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NN*KK; i++) w_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NN; i++) b_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Entered at a negedge with start low; that cycle becomes cycle 0.
  task automatic do_run(input bit hold, input bit pulse3);
    int e0 [NN];
    int e4 [NN];
    int runs = hold ? 2 : 1;
    int writes = 0;
    int jj, n, k;
    bit in_run, eb, ed, ew;
    for (int i = 0; i < NN; i++) begin
      e0[i] = model(i, 0);
      e4[i] = model(i, 4);
    end
    start = 1'b1;
    for (int j = 1; j <= runs*RUN_LEN + 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      in_run = (j <= runs*RUN_LEN);
      jj = ((j - 1) % RUN_LEN) + 1;
      eb = in_run && jj <= NN*PERIOD;
      ed = in_run && jj == RUN_LEN;
      ew = eb && (jj % PERIOD == 0);
      if (ew) begin
        last_addr = jj / PERIOD - 1;
        last0 = e0[last_addr];
        last4 = e4[last_addr];
      end
      check_eq("busy0", int'(busy0), int'(eb));
      check_eq("done0", int'(done0), int'(ed));
      check_eq("we0", int'(we0), int'(ew));
      check_eq("busy4", int'(busy4), int'(eb));
      check_eq("done4", int'(done4), int'(ed));
      check_eq("we4", int'(we4), int'(ew));
      check_eq("out_addr0", int'(oa0), last_addr);
      check_eq("out_addr4", int'(oa4), last_addr);
      check_eq("out_data0", int'(od0), last0);
      check_eq("out_data4", int'(od4), last4);
      if (eb && (jj % PERIOD) >= 1 && (jj % PERIOD) <= KK) begin
        n = jj / PERIOD;
        k = (jj % PERIOD) - 1;
        check_eq("in_addr", int'(ia0), k);
        check_eq("w_addr", int'(wa0), n*KK + k);
        check_eq("b_addr", int'(ba0), n);
      end
      writes += int'(we0);
      start = hold ? (j <= RUN_LEN) : (pulse3 && j == 3);
    end
    start = 1'b0;
    check_eq("write_count", writes, runs*NN);
  endtask

  task automatic reset_mid_run();
    int writes = 0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_eq("rst_busy", int'(busy0), 0);
    check_eq("rst_we", int'(we0), 0);
    check_eq("rst_done", int'(done0), 0);
    check_eq("rst_data", int'(od0), 0);
    check_eq("rst_busy4", int'(busy4), 0);
    last_addr = 0;
    last0 = 0;
    last4 = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < RUN_LEN + 2; j++) begin
      @(posedge clk);
      @(negedge clk);
      writes += int'(we0) + int'(we4);
      check_eq("post_rst_busy", int'(busy0), 0);
    end
    check_eq("post_rst_writes", writes, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_mem(1, 2, 3, -1, 0);
    repeat (2) @(negedge clk);
    check_eq("reset_busy", int'(busy0), 0);
    check_eq("reset_done", int'(done0), 0);
    check_eq("reset_we", int'(we0), 0);
    check_eq("reset_out_data", int'(od0), 0);
    check_eq("reset_out_addr", int'(oa0), 0);
    check_eq("reset_in_addr", int'(ia0), 0);
    check_eq("reset_w_addr", int'(wa0), 0);
    check_eq("reset_b_addr", int'(ba0), 0);
    last_addr = 0;
    last0 = 0;
    last4 = 0;
    reset = 1'b0;
    @(negedge clk);

    do_run(1'b0, 1'b0);                 // basic
    do_run(1'b0, 1'b1);                 // start pulse in cycle 3 ignored
    do_run(1'b1, 1'b0);                 // start held through done: back-to-back
    set_mem(127, 127, 127, -128, -128); // saturation both directions
    do_run(1'b0, 1'b0);
    set_mem(16, 8, 2, -8, 0);           // fixed point on the FRAC_BITS=4 instance
    do_run(1'b0, 1'b0);
    set_mem(1, 2, 3, -1, 0);
    reset_mid_run();
    do_run(1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      do_run(1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
